// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, alu_op/div_op bit positions and divider FSM encoding for ex_stage.
package ex_stage_pkg;

  localparam int ID_TO_EX_W   = 184;
  localparam int EX_TO_MEM_W  = 103;
  localparam int EX_TO_ID_W   = 39;
  localparam int ID_PAYLOAD_W = 152;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam int DIV_MODWU = 0;
  localparam int DIV_DIVWU = 1;
  localparam int DIV_MODW  = 2;
  localparam int DIV_DIVW  = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Payload occupies the low ID_PAYLOAD_W bits of id_to_ex_bus; upper bits are reserved.
  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        res_from_mem;
    logic        mem_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
  } id_payload_t;

endpackage

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - 32-bit radix-2 restoring divider, 32 iterations, result held in DONE until ack.
module ex_divider
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic        ack,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] q_reg, r_reg, d_reg, src1_reg;
  logic        neg_q, neg_r, div_zero;
  logic [31:0] a_mag, b_mag;
  logic [32:0] r_shift, diff;

  assign a_mag   = (is_signed & dividend[31]) ? -dividend : dividend;
  assign b_mag   = (is_signed & divisor[31])  ? -divisor  : divisor;
  assign r_shift = {r_reg, q_reg[31]};
  assign diff    = r_shift - {1'b0, d_reg};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start)        state_nxt = DIV_BUSY;
      DIV_BUSY: if (cnt == 5'd31) state_nxt = DIV_DONE;
      DIV_DONE: if (ack)          state_nxt = DIV_IDLE;
      default:                    state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIV_BUSY);
    done = (state == DIV_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= 5'd0;
      q_reg    <= 32'd0;
      r_reg    <= 32'd0;
      d_reg    <= 32'd0;
      src1_reg <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      cnt      <= 5'd0;
      q_reg    <= a_mag;
      r_reg    <= 32'd0;
      d_reg    <= b_mag;
      src1_reg <= dividend;
      neg_q    <= is_signed & (dividend[31] ^ divisor[31]);
      neg_r    <= is_signed & dividend[31];
      div_zero <= (divisor == 32'd0);
    end else if (state == DIV_BUSY) begin
      // q_reg doubles as the dividend shift register; its low bits collect quotient bits.
      cnt   <= cnt + 5'd1;
      q_reg <= {q_reg[30:0], ~diff[32]};
      r_reg <= diff[32] ? r_shift[31:0] : diff[31:0];
    end
  end

  assign quotient  = div_zero ? 32'hFFFF_FFFF : (neg_q ? -q_reg : q_reg);
  assign remainder = div_zero ? src1_reg      : (neg_r ? -r_reg : r_reg);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - pipeline EX stage: inline ALU, data SRAM request, optional divider under EX_DIV_EN.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   ex_allowin,
  input  logic                   id_to_ex_valid,
  input  logic [ID_TO_EX_W-1:0]  id_to_ex_bus,
  input  logic                   mem_allowin,
  output logic                   ex_to_mem_valid,
  output logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_W-1:0]  ex_to_id_bus,
  output logic                   data_sram_en,
  output logic [3:0]             data_sram_we,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata
);

  logic        ex_valid, ex_ready_go;
  id_payload_t ex_bus;
  logic [31:0] alu_result, ex_result, sra_result;
  logic [4:0]  shamt;
  logic        unused_reserved;

  assign unused_reserved = ^id_to_ex_bus[ID_TO_EX_W-1:ID_PAYLOAD_W];

  assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
  assign ex_to_mem_valid = ex_valid & ex_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid <= 1'b0;
      ex_bus   <= '0;
    end else begin
      if (ex_allowin) ex_valid <= id_to_ex_valid;
      if (id_to_ex_valid && ex_allowin) ex_bus <= id_to_ex_bus[ID_PAYLOAD_W-1:0];
    end
  end

  assign shamt      = ex_bus.src2[4:0];
  assign sra_result = $unsigned($signed(ex_bus.src1) >>> shamt);

  // alu_op is one-hot, so OR-ing the gated results selects the active operation.
  always_comb begin
    alu_result = 32'd0;
    if (ex_bus.alu_op[ALU_ADD])  alu_result |= ex_bus.src1 + ex_bus.src2;
    if (ex_bus.alu_op[ALU_SUB])  alu_result |= ex_bus.src1 - ex_bus.src2;
    if (ex_bus.alu_op[ALU_SLT])  alu_result |= {31'd0, $signed(ex_bus.src1) < $signed(ex_bus.src2)};
    if (ex_bus.alu_op[ALU_SLTU]) alu_result |= {31'd0, ex_bus.src1 < ex_bus.src2};
    if (ex_bus.alu_op[ALU_AND])  alu_result |= ex_bus.src1 & ex_bus.src2;
    if (ex_bus.alu_op[ALU_NOR])  alu_result |= ~(ex_bus.src1 | ex_bus.src2);
    if (ex_bus.alu_op[ALU_OR])   alu_result |= ex_bus.src1 | ex_bus.src2;
    if (ex_bus.alu_op[ALU_XOR])  alu_result |= ex_bus.src1 ^ ex_bus.src2;
    if (ex_bus.alu_op[ALU_SLL])  alu_result |= ex_bus.src1 << shamt;
    if (ex_bus.alu_op[ALU_SRL])  alu_result |= ex_bus.src1 >> shamt;
    if (ex_bus.alu_op[ALU_SRA])  alu_result |= sra_result;
    if (ex_bus.alu_op[ALU_LUI])  alu_result |= ex_bus.src2;
  end

`ifdef EX_DIV_EN
  logic        is_div, div_start, div_is_signed, div_busy, div_done;
  logic [31:0] div_q, div_r;

  assign is_div        = |ex_bus.div_op;
  assign div_start     = ex_valid & is_div & ~div_busy & ~div_done;
  assign div_is_signed = ex_bus.div_op[DIV_DIVW] | ex_bus.div_op[DIV_MODW];

  ex_divider u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .is_signed (div_is_signed),
    .ack       (mem_allowin),
    .dividend  (ex_bus.src1),
    .divisor   (ex_bus.src2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign ex_ready_go = ~is_div | div_done;
  assign ex_result   = ~is_div ? alu_result :
                       (ex_bus.div_op[DIV_DIVW] | ex_bus.div_op[DIV_DIVWU]) ? div_q : div_r;
`else
  logic unused_div_op;

  assign unused_div_op = ^ex_bus.div_op;
  assign ex_ready_go   = 1'b1;
  assign ex_result     = alu_result;
`endif

  assign ex_to_mem_bus = {ex_bus.pc, ex_bus.res_from_mem, ex_bus.rf_we, ex_bus.rf_waddr,
                          ex_result, ex_bus.rkd_value};
  assign ex_to_id_bus  = {ex_bus.rf_we & ex_valid, ex_bus.rf_waddr,
                          ex_bus.res_from_mem & ex_valid, ex_result};

  assign data_sram_en    = ex_valid & ex_ready_go & mem_allowin & (ex_bus.res_from_mem | ex_bus.mem_we);
  assign data_sram_we    = {4{ex_valid & ex_bus.mem_we & mem_allowin}};
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = ex_bus.rkd_value;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage; divide expectations follow EX_DIV_EN.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ex_allowin;
  logic         id_to_ex_valid;
  logic [183:0] id_to_ex_bus;
  logic         mem_allowin;
  logic         ex_to_mem_valid;
  logic [102:0] ex_to_mem_bus;
  logic [38:0]  ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_allowin      (ex_allowin),
    .id_to_ex_valid  (id_to_ex_valid),
    .id_to_ex_bus    (id_to_ex_bus),
    .mem_allowin     (mem_allowin),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ops 0..11 are ALU ops in alu_op bit order; 12..15 are div.w, mod.w, div.wu, mod.wu
  function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [4:0] sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return (sa < sb) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << sh;
      9:  return a >> sh;
      10: return sa >>> sh;
      11: return b;
`ifdef EX_DIV_EN
      12: return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : sa / sb;
      13: return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : sa % sb;
      14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      15: return (b == 0) ? a : a % b;
`endif
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] div_or_add(input logic [31:0] div_exp, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_DIV_EN
    return div_exp + 32'd0 * (a ^ b);
`else
    return a + b + 32'd0 * div_exp;
`endif
  endfunction

  function automatic logic [183:0] junk_bus();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, 24'($urandom)};
  endfunction

  task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int stall, input logic lw, input logic sw);
    logic [11:0] alu;
    logic [3:0]  dv;
    logic [31:0] pc, rkd;
    logic [4:0]  wa;
    logic        we, ready, ma;
    int          lat;
    pc  = $urandom;
    rkd = $urandom;
    wa  = 5'($urandom);
    we  = 1'($urandom);
    alu = (op < 12) ? 12'(1 << op) : 12'd1;
    dv  = (op >= 12) ? 4'(8 >> (op - 12)) : 4'd0;
    lat = 0;
`ifdef EX_DIV_EN
    if (op >= 12) lat = 33;
`endif
    @(negedge clk);
    id_to_ex_valid = 1'b1;
    id_to_ex_bus   = {$urandom, pc, alu, dv, a, b, rkd, lw, sw, we, wa};
    mem_allowin    = 1'b0;
    #1 check({tag, "/allowin"}, 128'(ex_allowin), 128'(1));
    @(posedge clk);
    for (int k = 0; k <= lat + stall; k++) begin
      @(negedge clk);
      id_to_ex_valid = 1'b0;
      id_to_ex_bus   = junk_bus();
      ma             = (k >= lat + stall);
      ready          = (k >= lat);
      mem_allowin    = ma;
      #1;
      check({tag, "/hs"}, 128'({ex_to_mem_valid, ex_allowin, data_sram_en, data_sram_we}),
            128'({ready, ready & ma, ready & ma & (lw | sw), {4{sw & ma}}}));
      if (ma) begin
        check({tag, "/mem_bus"}, 128'(ex_to_mem_bus), 128'({pc, lw, we, wa, exp_res, rkd}));
        check({tag, "/id_bus"}, 128'(ex_to_id_bus), 128'({we, wa, lw, exp_res}));
        check({tag, "/sram"}, 128'({data_sram_addr, data_sram_wdata}), 128'({exp_res, rkd}));
      end
    end
    @(negedge clk);
    mem_allowin = 1'($urandom);
    #1;
    check({tag, "/drain"},
          128'({ex_to_mem_valid, ex_allowin, data_sram_en, data_sram_we, ex_to_id_bus[38], ex_to_id_bus[32]}),
          128'({1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}));
  endtask

  initial begin
    logic [31:0] a, b;
    logic        seen;
    int          op, sel;

    resetn         = 1'b0;
    id_to_ex_valid = 1'b0;
    id_to_ex_bus   = '0;
    mem_allowin    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hs", 128'({ex_to_mem_valid, ex_allowin, data_sram_en, data_sram_we, ex_to_id_bus[38], ex_to_id_bus[32]}),
          128'({1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}));
    check("reset_mem_bus", 128'(ex_to_mem_bus), 128'(0));
    resetn = 1'b1;

    run_op("add", 0, 32'd5, 32'd7, 32'd12, 0, 1'b0, 1'b0);
    run_op("divw", 12, 32'hFFFF_FFF9, 32'd2, div_or_add(32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd2), 0, 1'b0, 1'b0);
    run_op("modw", 13, 32'hFFFF_FFF9, 32'd2, div_or_add(32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd2), 0, 1'b0, 1'b0);
    run_op("divwu_zero", 14, 32'd10, 32'd0, div_or_add(32'hFFFF_FFFF, 32'd10, 32'd0), 0, 1'b0, 1'b0);
    run_op("modwu_zero", 15, 32'd10, 32'd0, div_or_add(32'd10, 32'd10, 32'd0), 0, 1'b0, 1'b0);
    run_op("divw_ovf", 12, 32'h8000_0000, 32'hFFFF_FFFF, div_or_add(32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF), 0, 1'b0, 1'b0);
    run_op("modw_ovf", 13, 32'h8000_0000, 32'hFFFF_FFFF, div_or_add(32'd0, 32'h8000_0000, 32'hFFFF_FFFF), 0, 1'b0, 1'b0);
    run_op("store", 0, 32'h10, 32'hC, 32'h1C, 2, 1'b0, 1'b1);
    run_op("div_stall", 12, 32'd100, 32'd7, div_or_add(32'd14, 32'd100, 32'd7), 3, 1'b0, 1'b0);
    run_op("lui", 11, 32'h1234_5678, 32'hABCD_0000, 32'hABCD_0000, 1, 1'b1, 1'b0);

    // reset in the middle of an instruction held in EX
    @(negedge clk);
    id_to_ex_valid = 1'b1;
    id_to_ex_bus   = {32'd0, 32'h1C00_0000, 12'd1, 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3};
    mem_allowin    = 1'b0;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      id_to_ex_valid = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check("rst_mid_hs", 128'({ex_to_mem_valid, ex_allowin, data_sram_en, data_sram_we, ex_to_id_bus[38], ex_to_id_bus[32]}),
          128'({1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}));
    mem_allowin = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen   = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1 seen = seen | ex_to_mem_valid;
    end
    check("rst_no_result", 128'(seen), 128'(0));
    run_op("after_rst", 1, 32'd20, 32'd30, 32'hFFFF_FFF6, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(15);
      sel = $urandom_range(5);
      a   = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      sel = $urandom_range(6);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'd1 :
            (sel == 3) ? 32'($urandom_range(31)) : $urandom;
      sel = $urandom_range(2);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_model(op, a, b),
             $urandom_range(3), sel == 1, sel == 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
